// File: rtl/bam_seq_mul_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bam_seq_pkg
// Description : Shared types and helpers for the sequential broken-array
//               approximate multiplier controller: default operand width,
//               FSM state encoding, h/v field widths and the per-row keep mask.
// Revision    : 1.0 - initial release
// ============================================================================
package bam_seq_pkg;

    localparam int N_DEFAULT = 8;
    localparam int H_W       = $clog2(N_DEFAULT);
    localparam int V_W       = $clog2(2 * N_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit j of the mask is set when partial product a[j]&b[i] survives both
    // the horizontal break (row i >= h) and the vertical break (i+j >= v).
    function automatic logic [N_DEFAULT-1:0] row_mask(
        input logic [H_W-1:0] i,
        input logic [H_W-1:0] h,
        input logic [V_W-1:0] v,
        input logic           b_i
    );
        logic [N_DEFAULT-1:0] m;
        for (int j = 0; j < N_DEFAULT; j++) begin
            m[j] = b_i && (i >= h) && ((int'(i) + j) >= int'(v));
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bam_seq_mul_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bam_seq_mul_ctrl_if
// Description : Operand / result handshake bundle for bam_seq_mul_ctrl.
//               The slave modport is the multiplier, master is its
//               operand producer plus result consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bam_seq_mul_ctrl_if #(
    parameter int N = 8
);
    localparam int H_W = $clog2(N);
    localparam int V_W = $clog2(2 * N);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [H_W-1:0]   h;
    logic [V_W-1:0]   v;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out;
    logic             busy;

    modport slave (
        input  in_valid, a, b, h, v, out_ready,
        output in_ready, out_valid, out, busy
    );

    modport master (
        output in_valid, a, b, h, v, out_ready,
        input  in_ready, out_valid, out, busy
    );

endinterface
`default_nettype wire

// File: rtl/bam_seq_mul_ctrl_row_gen.sv
`default_nettype none
// ============================================================================
// Module      : bam_seq_row_gen
// Description : Combinational partial-product row former. Produces
//               ((a & m_i) << i) as a 2N-bit vector, where m_i is the keep
//               mask for row i under break levels h and v.
// Revision    : 1.0 - initial release
// ============================================================================
module bam_seq_row_gen
    import bam_seq_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  wire logic [N-1:0]           a_i,
    input  wire logic                   b_i,
    input  wire logic [$clog2(N)-1:0]   i_i,
    input  wire logic [$clog2(N)-1:0]   h_i,
    input  wire logic [$clog2(2*N)-1:0] v_i,
    output      logic [2*N-1:0]         row_o
);

    logic [N-1:0] w_mask;

    // The package helper is sized for the default width; other widths use
    // an equivalent inline loop.
    generate
        if (N == N_DEFAULT) begin : g_pkg_mask
            assign w_mask = row_mask(i_i, h_i, v_i, b_i);
        end else begin : g_loop_mask
            // Keep bit j iff row is set, not horizontally broken, and on or
            // above the vertical break diagonal.
            always_comb begin
                w_mask = '0;
                for (int j = 0; j < N; j++) begin
                    w_mask[j] = b_i && (i_i >= h_i) && ((int'(i_i) + j) >= int'(v_i));
                end
            end
        end
    endgenerate

    assign row_o = {{N{1'b0}}, (a_i & w_mask)} << i_i;

endmodule
`default_nettype wire

// File: rtl/bam_seq_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bam_seq_mul_ctrl
// Description : Sequential broken-array approximate unsigned multiplier.
//               Accumulates one partial-product row per cycle with runtime
//               horizontal (h) and vertical (v) break levels.
//               Optional macro BAM_SEQ_ROW_SKIP_EN: start RUN at row h so
//               broken rows cost no cycles (latency N-h instead of N).
// Revision    : 1.0 - initial release
// ============================================================================
module bam_seq_mul_ctrl
    import bam_seq_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    bam_seq_mul_ctrl_if.slave     bus
);

    localparam int H_W = $clog2(N);
    localparam int V_W = $clog2(2 * N);
    localparam logic [H_W-1:0] C_LAST_ROW = H_W'(N - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [H_W-1:0]   h_q, h_d;
    logic [V_W-1:0]   v_q, v_d;
    logic [H_W-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   w_row;

    bam_seq_row_gen #(
        .N (N)
    ) u_row_gen (
        .a_i   (a_q),
        .b_i   (b_q[cnt_q]),
        .i_i   (cnt_q),
        .h_i   (h_q),
        .v_i   (v_q),
        .row_o (w_row)
    );

    // State, latched operands, row counter and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            h_q     <= '0;
            v_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            h_q     <= h_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state and datapath update: accept in IDLE, one row per RUN cycle,
    // hold the result in DONE until the consumer takes it.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        h_d     = h_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    h_d     = bus.h;
                    v_d     = bus.v;
                    acc_d   = '0;
`ifdef BAM_SEQ_ROW_SKIP_EN
                    cnt_d   = bus.h;
`else
                    cnt_d   = '0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + w_row;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST_ROW) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out       = acc_q;

endmodule
`default_nettype wire

// File: doc/bam_seq_mul_ctrl.md
# bam_seq_mul_ctrl

- Sequential controller for a broken-array (BAM) approximate unsigned multiplier.
- Sequences one partial-product row per cycle into a 2N-bit accumulator.
- Runtime horizontal (h) and vertical (v) break levels select the approximation, replacing the fixed per-netlist h/v of the flat combinational BAM multipliers.
- Sits between an operand producer and a result consumer using valid/ready handshakes; used for area-constrained approximate datapaths and for sweeping h/v at run time.

## Interface
- N, 8, operand width (power of two, ≥4)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block idle, accepts operands
- a  input  N  multiplicand
- b  input  N  multiplier (row selector)
- h  input  $clog2(N)  horizontal break level; rows i<h dropped
- v  input  $clog2(2N)  vertical break level; bits with i+j<v dropped
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  2N  approximate product
- busy  output  1  high in RUN or DONE

## Operation
- Partial product a[j]&b[i] is kept iff i≥h and i+j≥v. `out` is the exact sum of the kept bits, so out ≤ a*b.
- Accumulator is 2N bits wide. Overflow is impossible.
- FSM states:
  - IDLE: in_ready=1.
    - On in_valid&&in_ready, latch a, b, h and v.
    - Clear the accumulator.
    - Set row counter to h (macro on) or 0 (macro off).
    - Go to RUN.
  - RUN: each cycle, add ((a & m_i) << i) to the accumulator, where m_i bit j = b[i] && i≥h && i+j≥v.
    - Increment the row counter.
    - After row N-1 is processed, go to DONE.
  - DONE: out_valid=1 and out = accumulator.
    - On out_ready, go to IDLE.
- Operands applied while not in IDLE are ignored. There is no queueing.
- v ≥ 2N-1 (including the all-ones encoding) drops every bit, so out=0.
- h is always in 0..N-1, so RUN lasts at least one cycle.
- Row generation is purely combinational from the latched registers.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - busy=0
  - out=0
  - accumulator, row counter and latched operands = 0
- in_ready is a decode of state==IDLE. out_valid is a decode of state==DONE. out is driven directly from the accumulator register.
- Latency: out_valid rises exactly R cycles after the accept edge.
  - R = N-h with BAM_SEQ_ROW_SKIP_EN.
  - R = N without BAM_SEQ_ROW_SKIP_EN.
- out and out_valid hold stable while out_valid && !out_ready.
- The result handshake edge returns the block to IDLE. in_ready is high in the following cycle, so a new accept cannot coincide with result handoff.
- Throughput: one operation per R+2 cycles at best (accept cycle, R RUN cycles, DONE cycle).
- Reset asserted mid-RUN or mid-DONE aborts immediately:
  - The pending result is discarded.
  - No spurious out_valid appears after release.

## Configuration
- BAM_SEQ_ROW_SKIP_EN
  - Defined: RUN starts at row h, giving data-dependent latency N-h. Broken rows cost no cycles.
  - Undefined: RUN always iterates rows 0..N-1 with broken rows masked to zero, giving fixed latency N.
  - `out` is bit-identical in both builds.

## Structure
- Package bam_seq_pkg holds:
  - default N
  - state enum (IDLE, RUN, DONE)
  - localparams for the h/v widths
  - function row_mask(i, h, v, b_i) returning the N-bit keep mask
- Sub-module bam_seq_row_gen (combinational) forms ((a & m_i) << i) as a 2N-bit vector from the latched a, b[i], i, h and v.
- The controller holds the FSM, counter, accumulator and handshake logic.

## Test plan
- h=7, v=7, a=0xFF, b=0x80 → out=0x7F80. Latency 1 with macro, 8 without.
- h=0, v=0, a=0xFF, b=0xFF → out=0xFE01 (exact). Latency 8 in both builds.
- h=7, v=7, a=0xFF, b=0x7F → out=0x0000 (all set rows broken).
- h=0, v=4, a=0x0F, b=0x0F → out=0x00B0 (176; exact 225 minus 49 dropped).
- Backpressure with a=0x03, b=0x05, h=0, v=0: hold out_ready=0 for 5 cycles in DONE → out=0x000F stable and in_ready=0. A new in_valid pulse in those cycles is ignored. After release, IDLE is reached and the next operation is correct.
- Assert rst_n=0 during the third RUN cycle → out_valid=0 and in_ready=1 after release. The next operation (a=0x10, b=0x10, h=0, v=0) yields 0x0100.
